// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern type, legal digit codes, error value
// and the capture FSM state type.
package seg7_pkg;

   // Pattern bit 6 is segment A, bit 0 is segment G.
   typedef logic [6:0] seg7_pattern_t;

   localparam seg7_pattern_t SEG7_0     = 7'b1111110;
   localparam seg7_pattern_t SEG7_1     = 7'b0110000;
   localparam seg7_pattern_t SEG7_2     = 7'b1101101;
   localparam seg7_pattern_t SEG7_3     = 7'b1111001;
   localparam seg7_pattern_t SEG7_4     = 7'b0110011;
   localparam seg7_pattern_t SEG7_5     = 7'b1011011;
   localparam seg7_pattern_t SEG7_6     = 7'b1011111;
   localparam seg7_pattern_t SEG7_7     = 7'b1110000;
   localparam seg7_pattern_t SEG7_8     = 7'b1111111;
   localparam seg7_pattern_t SEG7_9     = 7'b1111011;
   localparam seg7_pattern_t SEG7_BLANK = 7'b0000000;

   localparam logic [3:0] SEG7_ERR_VALUE = 4'hF;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StCaptured
   } cap_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to binary digit decoder.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       is_blank,
   output logic       is_error,
   output logic [3:0] value
);

   // Map each legal code to its digit; anything else but blank is an error.
   always_comb begin
      is_blank = 1'b0;
      is_error = 1'b0;
      value    = SEG7_ERR_VALUE;
      case (pattern)
         SEG7_0:     value = 4'd0;
         SEG7_1:     value = 4'd1;
         SEG7_2:     value = 4'd2;
         SEG7_3:     value = 4'd3;
         SEG7_4:     value = 4'd4;
         SEG7_5:     value = 4'd5;
         SEG7_6:     value = 4'd6;
         SEG7_7:     value = 4'd7;
         SEG7_8:     value = 4'd8;
         SEG7_9:     value = 4'd9;
         SEG7_BLANK: is_blank = 1'b1;
         default:    is_error = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures stable digits from a multiplexed 7-segment bus and streams
// {index, value} out over a valid/ready slot.
module seg7_capture_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int STABLE_CYCLES   = 16,
   parameter int SUPPRESS_REPEAT = 1,
   localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic                  i_Segment_A,
   input  logic                  i_Segment_B,
   input  logic                  i_Segment_C,
   input  logic                  i_Segment_D,
   input  logic                  i_Segment_E,
   input  logic                  i_Segment_F,
   input  logic                  i_Segment_G,
   input  logic [NUM_DIGITS-1:0] i_Digit_En,
   output logic                  o_Digit_Valid,
   input  logic                  i_Digit_Ready,
   output logic [IDX_W-1:0]      o_Digit_Index,
   output logic [3:0]            o_Binary_Num,
   output logic                  o_Pattern_Error,
   output logic                  o_Overrun
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

   logic [6:0]            seg_raw;
   logic [6:0]            seg_s1_q, seg_s2_q, pat_prev_q;
   logic [NUM_DIGITS-1:0] en_s1_q, en_s2_q, en_prev_q;
   cap_state_t            state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [3:0]            last_q [NUM_DIGITS];

   logic                  en_onehot;
   logic                  sample_change;
   logic [IDX_W-1:0]      cap_index;
   logic                  dec_blank, dec_error;
   logic [3:0]            dec_value;
   logic                  emit_try, emit_want, repeat_hit, slot_free, slot_load, overrun_d;

   logic                  valid_q, err_q, overrun_q;
   logic [IDX_W-1:0]      index_q;
   logic [3:0]            num_q;

   assign seg_raw = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                     i_Segment_E, i_Segment_F, i_Segment_G};

   // Two-flop synchronizers plus the previous-sample register used for change detection.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         seg_s1_q   <= '0;
         seg_s2_q   <= '0;
         pat_prev_q <= '0;
         en_s1_q    <= '0;
         en_s2_q    <= '0;
         en_prev_q  <= '0;
      end else begin
         seg_s1_q   <= seg_raw;
         seg_s2_q   <= seg_s1_q;
         pat_prev_q <= seg_s2_q;
         en_s1_q    <= i_Digit_En;
         en_s2_q    <= en_s1_q;
         en_prev_q  <= en_s2_q;
      end
   end

   assign en_onehot     = (en_s2_q != '0) && ((en_s2_q & (en_s2_q - EN_ONE)) == '0);
   assign sample_change = (en_s2_q != en_prev_q) || (seg_s2_q != pat_prev_q);

   // FSM state and stability counter registers.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next state: count identical one-hot samples, one capture per window.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (en_onehot) begin
               state_d = StSettle;
               count_d = CNT_ONE;
            end
         end
         StSettle: begin
            if (!en_onehot) begin
               state_d = StIdle;
               count_d = '0;
            end else if (sample_change) begin
               count_d = CNT_ONE;
            end else if (count_q == CNT_MAX) begin
               state_d = StCaptured;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         StCaptured: begin
            if (sample_change) begin
               if (en_onehot) begin
                  state_d = StSettle;
                  count_d = CNT_ONE;
               end else begin
                  state_d = StIdle;
                  count_d = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            count_d = '0;
         end
      endcase
   end

   // One-hot to binary index of the stable enable vector.
   always_comb begin
      cap_index = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_prev_q[i]) cap_index = cap_index | IDX_W'(i);
      end
   end

   seg7_pattern_decode u_decode (
      .pattern  (pat_prev_q),
      .is_blank (dec_blank),
      .is_error (dec_error),
      .value    (dec_value)
   );

   // Emit decision: the stable window matured this cycle; prev regs hold its sample.
   always_comb begin
      emit_try   = (state_q == StSettle) && (count_q == CNT_MAX);
      repeat_hit = (SUPPRESS_REPEAT != 0) && (last_q[cap_index] == dec_value);
      emit_want  = emit_try && !dec_blank && !repeat_hit;
      slot_free  = !valid_q || i_Digit_Ready;
      slot_load  = emit_want && slot_free;
      overrun_d  = emit_want && !slot_free;
   end

   // Output slot, overrun pulse and last-emitted memory.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         valid_q   <= 1'b0;
         index_q   <= '0;
         num_q     <= '0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) last_q[i] <= SEG7_ERR_VALUE;
      end else begin
         overrun_q <= overrun_d;
         if (slot_load) begin
            valid_q           <= 1'b1;
            index_q           <= cap_index;
            num_q             <= dec_value;
            err_q             <= dec_error;
            last_q[cap_index] <= dec_value;
         end else if (i_Digit_Ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_Digit_Valid   = valid_q;
   assign o_Digit_Index   = index_q;
   assign o_Binary_Num    = num_q;
   assign o_Pattern_Error = err_q;
   assign o_Overrun       = overrun_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder: directed scenarios plus a
// randomized window sequence checked against a window-level reference model.
module tb_seg7_capture_decoder;

   localparam int NUM_DIGITS = 4;
   localparam int STABLE     = 16;

   logic       clk   = 1'b0;
   logic       rst_l = 1'b0;
   logic [6:0] pat   = '0;
   logic [3:0] en    = '0;
   logic       ready = 1'b1;

   logic       valid;
   logic [1:0] idx;
   logic [3:0] num;
   logic       perr;
   logic       ovr;

   int errors = 0;
   int checks = 0;

   // Monitor-owned observations; tasks only read them.
   logic [6:0] got_q [$];
   int ovr_cnt   = 0;
   int err_cnt   = 0;
   int valid_cnt = 0;

   logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   always #5 clk = ~clk;

   seg7_capture_decoder #(
      .NUM_DIGITS      (NUM_DIGITS),
      .STABLE_CYCLES   (STABLE),
      .SUPPRESS_REPEAT (1)
   ) dut (
      .i_Clk           (clk),
      .i_Rst_L         (rst_l),
      .i_Segment_A     (pat[6]),
      .i_Segment_B     (pat[5]),
      .i_Segment_C     (pat[4]),
      .i_Segment_D     (pat[3]),
      .i_Segment_E     (pat[2]),
      .i_Segment_F     (pat[1]),
      .i_Segment_G     (pat[0]),
      .i_Digit_En      (en),
      .o_Digit_Valid   (valid),
      .i_Digit_Ready   (ready),
      .o_Digit_Index   (idx),
      .o_Binary_Num    (num),
      .o_Pattern_Error (perr),
      .o_Overrun       (ovr)
   );

   always @(negedge clk) begin
      if (valid && ready) got_q.push_back({perr, idx, num});
      if (ovr) ovr_cnt++;
      if (valid && perr) err_cnt++;
      if (valid) valid_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic hold(input logic [3:0] e, input logic [6:0] p, input int n);
      en  = e;
      pat = p;
      step(n);
   endtask

   task automatic test_reset;
      rst_l = 1'b0;
      en    = '0;
      pat   = '0;
      ready = 1'b1;
      step(3);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (idx !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", idx); end
      checks++; if (num !== 4'd0) begin errors++; $display("FAIL reset_num: got %0h want 0", num); end
      checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr); end
      @(negedge clk);
      rst_l = 1'b1;
      step(2);
      en  = 4'b0001;
      pat = 7'b1101101;
      // Edge 0 is the first edge that samples the new pins.
      for (int k = 0; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (valid !== (k == 18)) begin
            errors++;
            $display("FAIL latency_valid edge %0d: got %b want %b", k, valid, (k == 18));
         end
         if (k == 18) begin
            checks++;
            if ({perr, idx, num} !== {1'b0, 2'd0, 4'd2}) begin
               errors++;
               $display("FAIL latency_data: got err=%b idx=%0d num=%0h want err=0 idx=0 num=2",
                        perr, idx, num);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_scan;
      int base;
      base = got_q.size();
      for (int d = 0; d < 4; d++) hold(4'(1 << d), codes[d+1], 20);
      hold(4'b0000, 7'b0, 25);
      checks++;
      if (got_q.size() != base + 4) begin
         errors++;
         $display("FAIL scan_count: got %0d want 4", got_q.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         if (base + i < got_q.size()) begin
            checks++;
            if (got_q[base+i] !== {1'b0, 2'(i), 4'(i + 1)}) begin
               errors++;
               $display("FAIL scan_emit %0d: got %h want %h", i, got_q[base+i],
                        {1'b0, 2'(i), 4'(i + 1)});
            end
         end
      end
      base = got_q.size();
      for (int d = 0; d < 4; d++) hold(4'(1 << d), codes[d+1], 20);
      hold(4'b0000, 7'b0, 25);
      checks++;
      if (got_q.size() != base) begin
         errors++;
         $display("FAIL scan_repeat_suppressed: got %0d emits want 0", got_q.size() - base);
      end
   endtask

   task automatic test_error;
      int base;
      base = got_q.size();
      for (int t = 0; t < 6; t++) begin
         hold(4'b0100, 7'b0110000, 10);
         hold(4'b0100, 7'b0110001, 10);
      end
      hold(4'b0100, 7'b0110000, 10);
      checks++;
      if (got_q.size() != base) begin
         errors++;
         $display("FAIL toggle_no_emit: got %0d emits want 0", got_q.size() - base);
      end
      hold(4'b0100, 7'b0110001, 20);
      hold(4'b0000, 7'b0, 25);
      checks++;
      if (got_q.size() != base + 1) begin
         errors++;
         $display("FAIL error_count: got %0d want 1", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base] !== {1'b1, 2'd2, 4'hF}) begin
            errors++;
            $display("FAIL error_emit: got %h want %h", got_q[base], {1'b1, 2'd2, 4'hF});
         end
      end
   endtask

   task automatic test_overrun;
      int base, ovr0;
      base  = got_q.size();
      ovr0  = ovr_cnt;
      ready = 1'b0;
      hold(4'b0001, 7'b1011011, 20);
      hold(4'b0010, 7'b1110000, 20);
      hold(4'b0000, 7'b0, 5);
      checks++;
      if ({valid, perr, idx, num} !== {1'b1, 1'b0, 2'd0, 4'd5}) begin
         errors++;
         $display("FAIL overrun_held: got v=%b err=%b idx=%0d num=%0h want v=1 err=0 idx=0 num=5",
                  valid, perr, idx, num);
      end
      checks++;
      if (ovr_cnt - ovr0 != 1) begin
         errors++;
         $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - ovr0);
      end
      ready = 1'b1;
      step(3);
      hold(4'b0010, 7'b1110000, 20);
      hold(4'b0000, 7'b0, 25);
      checks++;
      if (got_q.size() != base + 2) begin
         errors++;
         $display("FAIL overrun_count: got %0d want 2", got_q.size() - base);
      end else begin
         checks++;
         if (got_q[base] !== {1'b0, 2'd0, 4'd5}) begin
            errors++;
            $display("FAIL overrun_first: got %h want %h", got_q[base], {1'b0, 2'd0, 4'd5});
         end
         checks++;
         if (got_q[base+1] !== {1'b0, 2'd1, 4'd7}) begin
            errors++;
            $display("FAIL overrun_rescan: got %h want %h", got_q[base+1], {1'b0, 2'd1, 4'd7});
         end
      end
   endtask

   task automatic test_illegal;
      int base, ovr0, err0, val0;
      base = got_q.size();
      ovr0 = ovr_cnt;
      err0 = err_cnt;
      val0 = valid_cnt;
      hold(4'b0011, 7'b1101101, 40);
      hold(4'b0001, 7'b0000000, 40);
      hold(4'b0000, 7'b0, 5);
      checks++;
      if (got_q.size() != base || valid_cnt != val0) begin
         errors++;
         $display("FAIL illegal_no_emit: got %0d emits %0d valid cycles want 0",
                  got_q.size() - base, valid_cnt - val0);
      end
      checks++;
      if (err_cnt != err0) begin errors++; $display("FAIL illegal_no_error: got %0d want 0", err_cnt - err0); end
      checks++;
      if (ovr_cnt != ovr0) begin errors++; $display("FAIL illegal_no_overrun: got %0d want 0", ovr_cnt - ovr0); end
   endtask

   task automatic test_reset_mid;
      int base, w;
      hold(4'b1000, 7'b1111011, 8);
      #2 rst_l = 1'b0;
      #1;
      checks++;
      if ({valid, perr, ovr, idx, num} !== '0) begin
         errors++;
         $display("FAIL mid_settle_reset: got v=%b err=%b ovr=%b idx=%0d num=%0h want all 0",
                  valid, perr, ovr, idx, num);
      end
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      #1;
      base = got_q.size();
      step(30);
      checks++;
      if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== {1'b0, 2'd3, 4'd9}) begin
         errors++;
         $display("FAIL mid_settle_reemit: got %0d emits last %h want 1 emit %h",
                  got_q.size() - base, got_q[got_q.size()-1], {1'b0, 2'd3, 4'd9});
      end
      ready = 1'b0;
      en    = 4'b1000;
      pat   = 7'b1111111;
      w     = 0;
      while (valid !== 1'b1 && w < 40) begin
         step(1);
         w++;
      end
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL valid_timeout: got %b want 1", valid); end
      #2 rst_l = 1'b0;
      #1;
      checks++;
      if ({valid, perr, ovr, idx, num} !== '0) begin
         errors++;
         $display("FAIL valid_reset: got v=%b err=%b ovr=%b idx=%0d num=%0h want all 0",
                  valid, perr, ovr, idx, num);
      end
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      ready = 1'b1;
      @(posedge clk);
      #1;
      base = got_q.size();
      step(30);
      checks++;
      if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== {1'b0, 2'd3, 4'd8}) begin
         errors++;
         $display("FAIL memory_cleared_reemit: got %0d emits last %h want 1 emit %h",
                  got_q.size() - base, got_q[got_q.size()-1], {1'b0, 2'd3, 4'd8});
      end
   endtask

   task automatic test_random;
      logic [6:0] exp_q [$];
      logic [3:0] last [NUM_DIGITS];
      logic [3:0] cur_e, e, v;
      logic [6:0] cur_p, p;
      int run, n, r, base, ovr0, low_run, di;
      bit captured, err;

      en    = '0;
      pat   = '0;
      ready = 1'b1;
      rst_l = 1'b0;
      step(2);
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_DIGITS; i++) last[i] = 4'hF;
      cur_e    = '0;
      cur_p    = '0;
      run      = 0;
      captured = 1'b1;
      base     = got_q.size();
      ovr0     = ovr_cnt;
      low_run  = 0;

      for (int wdx = 0; wdx < 70; wdx++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            e = cur_e;
            p = cur_p;
         end else begin
            r = $urandom_range(0, 99);
            e = (r < 85) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 70)      p = codes[$urandom_range(0, 9)];
            else if (r < 80) p = 7'b0;
            else             p = 7'($urandom_range(0, 127));
         end
         n = $urandom_range(STABLE - 4, STABLE + 8);

         // Model: one capture per run of identical one-hot samples reaching STABLE.
         if (e == cur_e && p == cur_p) begin
            run += n;
         end else begin
            cur_e    = e;
            cur_p    = p;
            run      = n;
            captured = 1'b0;
         end
         if (!captured && run >= STABLE && $onehot(e)) begin
            captured = 1'b1;
            if (p != 7'b0) begin
               v   = 4'hF;
               err = 1'b1;
               for (int c = 0; c < 10; c++) begin
                  if (codes[c] == p) begin
                     v   = 4'(c);
                     err = 1'b0;
                  end
               end
               di = 0;
               for (int b = 0; b < NUM_DIGITS; b++) if (e[b]) di = b;
               if (last[di] != v) begin
                  exp_q.push_back({err, 2'(di), v});
                  last[di] = v;
               end
            end
         end

         en  = e;
         pat = p;
         repeat (n) begin
            @(posedge clk);
            #1;
            if (low_run >= 3) begin
               ready   = 1'b1;
               low_run = 0;
            end else begin
               ready   = 1'($urandom_range(0, 1));
               low_run = ready ? 0 : low_run + 1;
            end
         end
      end
      ready = 1'b1;
      hold(4'b0000, 7'b0, 30);

      checks++;
      if (got_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL random_count: got %0d want %0d", got_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size()) begin
            checks++;
            if (got_q[base+i] !== exp_q[i]) begin
               errors++;
               $display("FAIL random_emit %0d: got %h want %h", i, got_q[base+i], exp_q[i]);
            end
         end
      end
      checks++;
      if (ovr_cnt != ovr0) begin errors++; $display("FAIL random_overrun: got %0d want 0", ovr_cnt - ovr0); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_scan();
      test_error();
      test_overrun();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
